// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate-pair generator with programmable dead time and latched fault shutdown.
// Optional pwm_in glitch filter enabled by defining DDS_PWM_GLITCH_FILTER_EN.
module pwm_deadtime_gen #(
  parameter int unsigned DT_WIDTH      = 8,
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                gate_hi,
  output logic                gate_lo,
  output logic                fault_latched,
  output logic                in_deadtime
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_DT_HL = 3'd3,
    S_DT_LH = 3'd4
  } state_t;

  state_t              state;
  logic                pwm_q;
  logic [DT_WIDTH-1:0] count;
  logic [DT_WIDTH-1:0] dt_load_c;

  // Counter preload is D-1 where D = max(dead_time, 1), so a zero request still gives one dead cycle
  assign dt_load_c = (dead_time == '0) ? '0 : dead_time - DT_WIDTH'(1);

`ifdef DDS_PWM_GLITCH_FILTER_EN
  localparam int unsigned HIST_W = GLITCH_CYCLES - 1;

  logic [HIST_W-1:0] hist;
  logic [HIST_W:0]   window_c;

  assign window_c = {hist, pwm_in};

  // pwm_q follows pwm_in only once the last GLITCH_CYCLES samples all agree
  always_ff @(posedge clk) begin
    if (reset) begin
      hist  <= '0;
      pwm_q <= 1'b0;
    end else begin
      hist <= window_c[HIST_W-1:0];
      if ((&window_c) || !(|window_c)) begin
        pwm_q <= pwm_in;
      end
    end
  end
`else
  // Single retiming stage for the comparator output
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_in;
    end
  end
`endif

  // Gate FSM; outputs are written alongside the state so they are glitch-free flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_OFF;
      gate_hi       <= 1'b0;
      gate_lo       <= 1'b0;
      fault_latched <= 1'b0;
      in_deadtime   <= 1'b0;
      count         <= '0;
    end else begin
      if (fault) begin
        fault_latched <= 1'b1;
      end else if (fault_clr) begin
        fault_latched <= 1'b0;
      end

      if (fault || !enable) begin
        // Both gates low is always safe, so shutdown skips the dead-time interval
        state       <= S_OFF;
        gate_hi     <= 1'b0;
        gate_lo     <= 1'b0;
        in_deadtime <= 1'b0;
        count       <= '0;
      end else begin
        unique case (state)
          S_OFF: begin
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
            if (!fault_latched) begin
              state       <= pwm_q ? S_DT_LH : S_DT_HL;
              in_deadtime <= 1'b1;
              count       <= dt_load_c;
            end
          end
          S_HI: begin
            if (!pwm_q) begin
              state       <= S_DT_HL;
              gate_hi     <= 1'b0;
              in_deadtime <= 1'b1;
              count       <= dt_load_c;
            end
          end
          S_LO: begin
            if (pwm_q) begin
              state       <= S_DT_LH;
              gate_lo     <= 1'b0;
              in_deadtime <= 1'b1;
              count       <= dt_load_c;
            end
          end
          S_DT_HL, S_DT_LH: begin
            // Exit target is whatever pwm_q says on the expiry cycle
            if (count == '0) begin
              state       <= pwm_q ? S_HI : S_LO;
              gate_hi     <= pwm_q;
              gate_lo     <= !pwm_q;
              in_deadtime <= 1'b0;
            end else begin
              count <= count - DT_WIDTH'(1);
            end
          end
          default: begin
            state       <= S_OFF;
            gate_hi     <= 1'b0;
            gate_lo     <= 1'b0;
            in_deadtime <= 1'b0;
            count       <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen: directed scenarios plus random stimulus vs a behavioural model.
module tb_pwm_deadtime_gen;

  localparam int unsigned DT_WIDTH      = 8;
  localparam int unsigned GLITCH_CYCLES = 3;
`ifdef DDS_PWM_GLITCH_FILTER_EN
  localparam int FILT_N = GLITCH_CYCLES;
`else
  localparam int FILT_N = 1;
`endif
  localparam int LAT = FILT_N - 1;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                enable    = 1'b0;
  logic                pwm_in    = 1'b0;
  logic                fault     = 1'b0;
  logic                fault_clr = 1'b0;
  logic [DT_WIDTH-1:0] dead_time = DT_WIDTH'(4);
  logic                gate_hi;
  logic                gate_lo;
  logic                fault_latched;
  logic                in_deadtime;

  int errors = 0;
  int checks = 0;

  pwm_deadtime_gen #(
    .DT_WIDTH      (DT_WIDTH),
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pwm_in        (pwm_in),
    .dead_time     (dead_time),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .fault_latched (fault_latched),
    .in_deadtime   (in_deadtime)
  );

  always #5 clk = ~clk;

  // Behavioural model: "off" flag, remaining dead cycles, driven side, and a run-length input filter
  bit m_off  = 1'b1;
  bit m_lvl  = 1'b0;
  bit m_flt  = 1'b0;
  bit m_pq   = 1'b0;
  bit m_last = 1'b0;
  int m_dt   = 0;
  int m_run  = 0;

  always @(posedge clk) begin
    int d;
    bit old_flt;
    d = (dead_time == 0) ? 1 : int'(dead_time);
    if (reset) begin
      m_off = 1'b1; m_dt = 0; m_lvl = 1'b0; m_flt = 1'b0;
      m_pq = 1'b0; m_last = 1'b0; m_run = FILT_N - 1;
    end else begin
      old_flt = m_flt;
      if (fault) m_flt = 1'b1;
      else if (fault_clr) m_flt = 1'b0;
      if (fault || !enable) begin
        m_off = 1'b1; m_dt = 0;
      end else if (m_off) begin
        if (!old_flt) begin m_off = 1'b0; m_dt = d; end
      end else if (m_dt > 0) begin
        m_dt = m_dt - 1;
        if (m_dt == 0) m_lvl = m_pq;
      end else if (m_pq != m_lvl) begin
        m_dt = d;
      end
      if (pwm_in == m_last) begin
        if (m_run < 1000) m_run = m_run + 1;
      end else begin
        m_last = pwm_in; m_run = 1;
      end
      if (m_run >= FILT_N) m_pq = pwm_in;
    end
  end

  function automatic logic [3:0] exp_vec();
    logic h, l, dt;
    h  = !m_off && (m_dt == 0) && m_lvl;
    l  = !m_off && (m_dt == 0) && !m_lvl;
    dt = !m_off && (m_dt > 0);
    return {h, l, m_flt, dt};
  endfunction

  function automatic logic [3:0] dut_vec();
    return {gate_hi, gate_lo, fault_latched, in_deadtime};
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    dead_time = DT_WIDTH'(4);
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 4'b0000);
    end
    reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_startup();
    int n_dt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL startup_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (in_deadtime) n_dt++;
    end
    checks++;
    if (n_dt != 4) begin errors++; $display("FAIL startup_dt_cycles got=%0d exp=4", n_dt); end
    checks++;
    if ({gate_hi, gate_lo} !== 2'b01) begin
      errors++; $display("FAIL startup_gate got=%b exp=01", {gate_hi, gate_lo});
    end
  endtask

  task automatic test_lo_to_hi();
    logic [3:0] v [12];
    int fall = -1;
    int bl = 0;
    pwm_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL lo_to_hi_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      v[i] = dut_vec();
    end
    for (int i = 0; i < 12; i++) begin
      if (fall < 0 && !v[i][2]) fall = i;
      if (v[i][3:2] == 2'b00) bl++;
    end
    checks++;
    if (fall != LAT + 1) begin errors++; $display("FAIL lo_fall_index got=%0d exp=%0d", fall, LAT + 1); end
    checks++;
    if (bl != 4) begin errors++; $display("FAIL lo_to_hi_both_low got=%0d exp=4", bl); end
    checks++;
    if (v[LAT+5][3] !== 1'b1) begin errors++; $display("FAIL hi_rise got=%b exp=1", v[LAT+5][3]); end
  endtask

  task automatic test_dt_zero();
    int bl = 0;
    dead_time = '0;
    pwm_in = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL dt_zero_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (!gate_hi && !gate_lo) bl++;
      if (i % 20 == 19) pwm_in = ~pwm_in;
    end
    checks++;
    if (bl != 4) begin errors++; $display("FAIL dt_zero_both_low got=%0d exp=4", bl); end
  endtask

  task automatic test_short_pulse();
    int bl = 0;
    int hi_seen = 0;
    int exp_bl = (FILT_N > 2) ? 0 : 8;
    dead_time = DT_WIDTH'(8);
    pwm_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL pulse_setup_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (gate_lo !== 1'b1) begin errors++; $display("FAIL pulse_start_lo got=%b exp=1", gate_lo); end
    pwm_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL pulse_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (!gate_hi && !gate_lo) bl++;
      if (gate_hi) hi_seen++;
      if (i == 1) pwm_in = 1'b0;
      if (i == 3) dead_time = DT_WIDTH'(2);
    end
    checks++;
    if (bl != exp_bl) begin errors++; $display("FAIL pulse_both_low got=%0d exp=%0d", bl, exp_bl); end
    checks++;
    if (hi_seen != 0 || gate_lo !== 1'b1) begin
      errors++; $display("FAIL pulse_swallowed hi_cycles=%0d lo=%b exp hi_cycles=0 lo=1", hi_seen, gate_lo);
    end
    dead_time = DT_WIDTH'(4);
  endtask

  task automatic test_fault();
    logic [3:0] v [12];
    int n_dt = 0;
    pwm_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL fault_setup_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (gate_hi !== 1'b1) begin errors++; $display("FAIL fault_start_hi got=%b exp=1", gate_hi); end
    fault = 1'b1; fault_clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL fault_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      v[i] = dut_vec();
      if (in_deadtime) n_dt++;
      fault     = (i + 1 == 2);
      fault_clr = (i + 1 == 2) || (i + 1 == 4);
    end
    checks++;
    if (v[0] !== 4'b0010) begin errors++; $display("FAIL fault_shutdown got=%b exp=0010", v[0]); end
    checks++;
    if (v[2] !== 4'b0010) begin errors++; $display("FAIL fault_wins_clr got=%b exp=0010", v[2]); end
    checks++;
    if (v[4] !== 4'b0000) begin errors++; $display("FAIL fault_cleared got=%b exp=0000", v[4]); end
    checks++;
    if (n_dt != 4) begin errors++; $display("FAIL fault_restart_dt got=%0d exp=4", n_dt); end
    checks++;
    if (v[9] !== 4'b1000) begin errors++; $display("FAIL fault_restart_hi got=%b exp=1000", v[9]); end
  endtask

  task automatic test_enable();
    int n_dt = 0;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 4'b0000) begin errors++; $display("FAIL enable_off got=%b exp=0000", dut_vec()); end
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL enable_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (in_deadtime) n_dt++;
    end
    checks++;
    if (n_dt != 4 || gate_hi !== 1'b1) begin
      errors++; $display("FAIL enable_restart dt=%0d hi=%b exp dt=4 hi=1", n_dt, gate_hi);
    end
  endtask

  task automatic test_reset_mid_dt();
    bit found = 1'b0;
    pwm_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL rst_setup_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    pwm_in = 1'b1;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (in_deadtime) begin found = 1'b1; reset = 1'b1; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_wait_dt timeout got=no_deadtime exp=deadtime");
    end else begin
      @(negedge clk);
      reset = 1'b0;
      if (dut_vec() !== 4'b0000) begin
        errors++; $display("FAIL rst_mid_dt got=%b exp=0000", dut_vec());
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL rst_recover_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

`ifdef DDS_PWM_GLITCH_FILTER_EN
  task automatic test_glitch();
    int bad = 0;
    pwm_in = 1'b0;
    repeat (15) @(negedge clk);
    pwm_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) pwm_in = 1'b0;
      if ({gate_hi, gate_lo, in_deadtime} !== 3'b010) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL glitch_filtered bad_cycles=%0d exp=0", bad); end
  endtask
`endif

  task automatic test_random();
    int run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec() || (gate_hi && gate_lo)) begin
        errors++; $display("FAIL random_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (run_left == 0) begin
        pwm_in   = ~pwm_in;
        run_left = int'($urandom_range(1, 14));
      end
      run_left--;
      if ($urandom_range(0, 49) == 0) dead_time = DT_WIDTH'($urandom_range(0, 6));
      fault     = ($urandom_range(0, 299) == 0);
      fault_clr = ($urandom_range(0, 29) == 0);
      enable    = ($urandom_range(0, 199) != 0);
      reset     = ($urandom_range(0, 799) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lo_to_hi();
    test_dt_zero();
    test_short_pulse();
    test_fault();
    test_enable();
    test_reset_mid_dt();
`ifdef DDS_PWM_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
